r51_exec: RTL
=============

Name: r51_exec

Overview:
- Execution sequencer for the R51 little-man machine.
- Reads the 8-bit program words that the R51 loader (button-driven RAM1 writer) has stored, decodes them, and executes them against a 4-bit accumulator.
- Sits on the read side of the program RAM; the loader owns the write side.
- Results leave through a valid/ready output port.

Parameters:
ADDR_WIDTH, 3, program memory address width; PC wraps at 2**ADDR_WIDTH-1 -> 0
DATA_WIDTH, 8, program word width; opcode = word[7:4], operand = word[3:0]

Ports:
timer555  in  1  clock, rising edge
reset_count  in  1  asynchronous, active-high reset
run  in  1  start/restart request, level-sampled in IDLE and HALT
mem_addr  out  ADDR_WIDTH  program RAM read address
mem_rd  out  1  read strobe; RAM returns mem_data one clock after the edge where mem_rd=1
mem_data  in  DATA_WIDTH  program RAM read data
out_data  out  4  value emitted by the OUT instruction
out_valid  out  1  out_data valid; held until accepted
out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
acc  out  4  accumulator
carry  out  1  carry/borrow flag from the last ADD/SUB
pc  out  ADDR_WIDTH  program counter
halted  out  1  high in HALT state
busy  out  1  high in FETCH, LATCH, EXEC and OUT_WAIT

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - pc, acc, carry, ir, out_data and mem_addr are 0.
  - mem_rd, out_valid, halted and busy are 0.
  - Reset mid-instruction or mid-handshake aborts at once and drops out_valid.
- States: IDLE, FETCH, LATCH, EXEC, OUT_WAIT, HALT. All outputs are registered.
- IDLE: run=1 at an edge -> FETCH, pc=0.
- FETCH (1 cycle): mem_addr=pc, mem_rd=1 -> LATCH.
- LATCH (1 cycle): ir <= mem_data, mem_rd=0 -> EXEC.
- EXEC (1 cycle): act on ir[7:4], operand k=ir[3:0]:
  - 0 HLT: -> HALT; pc unchanged.
  - 1 LDI: acc=k.
  - 2 ADD: {carry,acc}=acc+k, a 5-bit sum.
  - 3 SUB: acc=(acc-k) mod 16; carry=1 if k>acc (borrow).
  - 4 OUT: out_data=acc, out_valid=1 -> OUT_WAIT.
  - 5 JMP: pc=k[ADDR_WIDTH-1:0].
  - 6 JZ: if acc==0, pc=k[ADDR_WIDTH-1:0].
  - 7 JC: if carry==1, pc=k[ADDR_WIDTH-1:0].
  - 8..15: NOP.
  - A non-jumping, non-HLT instruction sets pc=pc+1 modulo 2**ADDR_WIDTH.
  - Every instruction except HLT and OUT returns to FETCH.
  - Flags change only on ADD and SUB. Jump tests use acc and carry values from before EXEC.
- OUT_WAIT:
  - out_valid and out_data stay stable.
  - Each edge with out_ready=1 clears out_valid, sets pc=pc+1 and moves to FETCH.
  - out_ready=1 in the same cycle out_valid first rises is accepted on the next edge; minimum OUT cost is 4 cycles.
- Timing: a non-OUT instruction takes exactly 3 cycles (FETCH, LATCH, EXEC).
- HALT:
  - halted=1; acc and carry are held.
  - run=1 -> FETCH with pc=0. acc and carry are not cleared on restart.
- run is ignored outside IDLE and HALT.
- PC wrap: the instruction at the last address with no jump continues at address 0.
- mem_addr is driven only in FETCH; it holds its last value otherwise.

Test Plan:
- Add and output:
  - Stimulus: RAM={0x13,0x24,0x40,0x00}; pulse run, hold out_ready=1.
  - Response: out_valid rises with out_data=7; accepted in one cycle; halted=1 with pc=3, acc=7, carry=0.
  - Timing: run edge to halted rising is 13 cycles.
- Backpressure:
  - Stimulus: same program, out_ready=0 for 10 cycles, then 1.
  - Response: out_valid and out_data=7 stay stable for all 10 cycles; a single acceptance; HALT follows.
- Carry and JC:
  - Stimulus: RAM={0x1F,0x22,0x75,0x40,0x00,0x1A,0x40,0x00}.
  - Response: acc=1 with carry=1; the jump is taken to 5; a single output with out_data=10 (0xA); halted with pc=7.
- Borrow, JZ and wrap:
  - Program 1: RAM={0x12,0x33,0x40,0x00}. Required: out_data=15 (0xF) with carry=1.
  - Program 2: RAM[0..7]={0x10,0x66,0x80,0x80,0x80,0x80,0x41,0x80}. Required: the JZ jump is taken to 6; out_data=0; pc wraps 7->0 and execution repeats.
- Reset mid-handshake:
  - Stimulus: assert reset_count while in OUT_WAIT, between clock edges.
  - Response: out_valid, busy, pc and acc go to 0 immediately; state is IDLE; run restarts from pc 0.
- Restart from HALT:
  - Stimulus: after the first program halts with acc=7, pulse run.
  - Response: re-executes from pc=0; acc is not cleared before LDI; run pulsed while busy has no effect.

Source files
------------

// File: rtl/r51_exec.sv
// rtl/r51_exec.sv - R51 execution sequencer: fetch/latch/exec over program RAM, 4-bit accumulator, valid/ready output port.
module r51_exec #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  timer555,
   input  logic                  reset_count,
   input  logic                  run,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [3:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            acc,
   output logic                  carry,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_OUT_WAIT, S_HALT
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [3:0]            r_acc;
   logic                  r_carry;
   logic [DATA_WIDTH-1:0] r_ir;
   logic [3:0]            r_out_data;
   logic                  r_out_valid;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_mem_rd;
   logic                  r_halted;
   logic                  r_busy;

   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] w_pc_next;
   logic [3:0]            w_acc_next;
   logic                  w_carry_next;
   logic [3:0]            w_out_data_next;
   logic                  w_out_valid_next;
   logic [3:0]            w_opcode;
   logic [3:0]            w_k;
   logic [ADDR_WIDTH-1:0] w_target;
   logic [ADDR_WIDTH-1:0] w_pc_inc;
   logic [4:0]            w_sum;
   logic [4:0]            w_diff;

   assign w_opcode = r_ir[DATA_WIDTH-1 -: 4];
   assign w_k      = r_ir[3:0];
   assign w_target = ADDR_WIDTH'(w_k);
   assign w_pc_inc = r_pc + ADDR_WIDTH'(1);
   assign w_sum    = {1'b0, r_acc} + {1'b0, w_k};
   // Bit 4 of the 5-bit difference is the borrow (k > acc).
   assign w_diff   = {1'b0, r_acc} - {1'b0, w_k};

   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_acc_next       = r_acc;
      w_carry_next     = r_carry;
      w_out_data_next  = r_out_data;
      w_out_valid_next = r_out_valid;
      case (r_state)
         S_IDLE, S_HALT: begin
            if (run) begin
               w_state_next = S_FETCH;
               w_pc_next    = '0;
            end
         end
         S_FETCH: w_state_next = S_LATCH;
         S_LATCH: w_state_next = S_EXEC;
         S_EXEC: begin
            w_state_next = S_FETCH;
            w_pc_next    = w_pc_inc;
            case (w_opcode)
               4'd0: begin
                  w_state_next = S_HALT;
                  w_pc_next    = r_pc;
               end
               4'd1: w_acc_next = w_k;
               4'd2: {w_carry_next, w_acc_next} = w_sum;
               4'd3: {w_carry_next, w_acc_next} = w_diff;
               4'd4: begin
                  w_out_data_next  = r_acc;
                  w_out_valid_next = 1'b1;
                  w_state_next     = S_OUT_WAIT;
                  w_pc_next        = r_pc;
               end
               4'd5: w_pc_next = w_target;
               4'd6: if (r_acc == 4'd0) w_pc_next = w_target;
               4'd7: if (r_carry) w_pc_next = w_target;
               default: ;
            endcase
         end
         S_OUT_WAIT: begin
            if (out_ready) begin
               w_out_valid_next = 1'b0;
               w_pc_next        = w_pc_inc;
               w_state_next     = S_FETCH;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge timer555 or posedge reset_count) begin
      if (reset_count) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_ir        <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_rd    <= 1'b0;
         r_halted    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pc        <= w_pc_next;
         r_acc       <= w_acc_next;
         r_carry     <= w_carry_next;
         r_out_data  <= w_out_data_next;
         r_out_valid <= w_out_valid_next;
         if (r_state == S_LATCH) r_ir <= mem_data;
         if (w_state_next == S_FETCH) r_mem_addr <= w_pc_next;
         r_mem_rd    <= (w_state_next == S_FETCH);
         r_halted    <= (w_state_next == S_HALT);
         r_busy      <= (w_state_next == S_FETCH) || (w_state_next == S_LATCH) ||
                        (w_state_next == S_EXEC)  || (w_state_next == S_OUT_WAIT);
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_rd    = r_mem_rd;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign acc       = r_acc;
   assign carry     = r_carry;
   assign pc        = r_pc;
   assign halted    = r_halted;
   assign busy      = r_busy;

endmodule
